// File: rtl/timestamp_extract.sv
// Passive tap on the sync-path AXI-stream: unpacks the timestamp slots carried in the
// first beat of each sync packet and queues them as rx-tick tagged records for the host.
module timestamp_extract #(
   parameter logic [11:0] SYNC_VLAN_ID = 12'h05A,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          NUM_SLOTS    = 3
) (
   input  logic                        axis_aclk,
   input  logic                        axis_areset,
   input  logic                        i_axis_tvalid,
   input  logic [511:0]                i_axis_tdata,
   input  logic [63:0]                 i_axis_tkeep,
   input  logic                        i_axis_tlast,
   input  logic                        i_axis_tready,
   input  logic [63:0]                 i_curr_tick,
   output logic                        o_rec_valid,
   input  logic                        i_rec_ready,
   output logic [161:0]                o_rec_data,
   output logic                        o_rec_last,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
   output logic                        o_sync_seen,
   output logic [31:0]                 o_rec_count,
   output logic [31:0]                 o_drop_count
);

   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int LW       = AW + 1;
   localparam int RW       = 163;
   localparam int SLOT_END = 144 + 96 * NUM_SLOTS;
   localparam int KEEP_END = 18 + 12 * NUM_SLOTS;

   typedef enum logic {ST_SOF, ST_MID} frame_state_t;

   frame_state_t         state;
   logic                 beat_acc;
   logic                 sync_beat;
   logic                 busy;
   logic                 capture;
   logic                 drop_busy;
   logic [NUM_SLOTS-1:0] occ_mask;
   logic [NUM_SLOTS-1:0] pend_mask;
   logic [NUM_SLOTS-1:0] cur_bit;
   logic [NUM_SLOTS-1:0] rem_mask;
   logic [95:0]          slot_q [NUM_SLOTS];
   logic [95:0]          cur_slot;
   logic [1:0]           cur_idx;
   logic [63:0]          rx_tick_q;
   logic [RW-1:0]        push_rec;

   logic [RW-1:0]        mem [FIFO_DEPTH];
   logic [RW-1:0]        rd_word;
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [LW-1:0]        fifo_level;
   logic                 full;
   logic                 pop;
   logic                 wr_en;
   logic                 drop_full;
   logic [32:0]          drop_sum;
   logic                 unused_bits;

   assign beat_acc  = i_axis_tvalid & i_axis_tready;
   assign sync_beat = beat_acc && (state == ST_SOF)
                      && (i_axis_tdata[103:96] == 8'h81) && (i_axis_tdata[111:104] == 8'h00)
                      && ({i_axis_tdata[115:112], i_axis_tdata[127:120]} == SYNC_VLAN_ID);
   assign busy      = |pend_mask;
   assign capture   = sync_beat & ~busy;
   assign drop_busy = sync_beat & busy;

   // A slot counts only if it is not the DEADBEEF filler and all of its bytes are kept
   always_comb begin
      occ_mask = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         occ_mask[k] = (i_axis_tdata[144+96*k +: 32] != 32'hDEADBEEF)
                       && (&i_axis_tkeep[18+12*k +: 12]);
      end
   end

   // Serializer always emits the lowest pending slot, giving ascending slot order
   always_comb begin
      cur_idx  = '0;
      cur_slot = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (pend_mask[k]) begin
            cur_idx  = 2'(k);
            cur_slot = slot_q[k];
         end
      end
   end

   assign cur_bit  = pend_mask & (~pend_mask + NUM_SLOTS'(1));
   assign rem_mask = pend_mask & ~cur_bit;
   assign push_rec = {cur_idx, cur_slot, rx_tick_q, (rem_mask == '0)};

   assign full      = (fifo_level == LW'(FIFO_DEPTH));
   assign pop       = o_rec_valid & i_rec_ready;
   assign wr_en     = busy & (~full | pop);
   assign drop_full = busy & full & ~pop;
   assign drop_sum  = {1'b0, o_drop_count} + {32'd0, drop_full} + {32'd0, drop_busy};

   assign rd_word      = mem[rd_ptr];
   assign o_rec_valid  = (fifo_level != '0);
   assign o_rec_data   = o_rec_valid ? rd_word[RW-1:1] : '0;
   assign o_rec_last   = o_rec_valid & rd_word[0];
   assign o_fifo_level = fifo_level;

   assign unused_bits = ^{i_axis_tdata[511:SLOT_END], i_axis_tdata[143:128],
                          i_axis_tdata[119:116], i_axis_tdata[95:0],
                          i_axis_tkeep[63:KEEP_END], i_axis_tkeep[17:0]};

   always_ff @(posedge axis_aclk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_rec;
      end
   end

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state        <= ST_SOF;
         pend_mask    <= '0;
         rx_tick_q    <= '0;
         o_sync_seen  <= 1'b0;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_q[k] <= '0;
         end
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         o_rec_count  <= '0;
         o_drop_count <= '0;
      end else begin
         if (beat_acc) begin
            case (state)
               ST_SOF:  state <= i_axis_tlast ? ST_SOF : ST_MID;
               ST_MID:  state <= i_axis_tlast ? ST_SOF : ST_MID;
               default: state <= ST_SOF;
            endcase
         end

         o_sync_seen <= capture;
         if (capture) begin
            pend_mask <= occ_mask;
            rx_tick_q <= i_curr_tick;
            for (int k = 0; k < NUM_SLOTS; k++) begin
               slot_q[k] <= i_axis_tdata[144+96*k +: 96];
            end
         end else if (busy) begin
            pend_mask <= rem_mask;
         end

         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase

         if (wr_en && (o_rec_count != '1)) begin
            o_rec_count <= o_rec_count + 32'd1;
         end
         o_drop_count <= drop_sum[32] ? '1 : drop_sum[31:0];
      end
   end

endmodule

// File: tb/tb_timestamp_extract.sv
// Bench for timestamp_extract: directed scenarios plus random traffic, compared every
// cycle against a queue-based model of the record stream and counters.
module tb_timestamp_extract;

   localparam int          DEPTH = 4;
   localparam logic [11:0] VID   = 12'h05A;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] nb;
      logic [63:0] tx;
      logic [63:0] rx;
      logic        last;
   } rec_t;

   logic         axis_aclk = 1'b0;
   logic         axis_areset = 1'b0;
   logic         tvalid = 1'b0;
   logic [511:0] tdata = '0;
   logic [63:0]  tkeep = '0;
   logic         tlast = 1'b0;
   logic         tready = 1'b0;
   logic [63:0]  curr_tick = '0;
   logic         rec_ready = 1'b0;
   logic         o_rec_valid;
   logic [161:0] o_rec_data;
   logic         o_rec_last;
   logic [2:0]   o_fifo_level;
   logic         o_sync_seen;
   logic [31:0]  o_rec_count;
   logic [31:0]  o_drop_count;

   rec_t mq[$];
   rec_t mpend[$];
   int   m_recs;
   int   m_drops;
   bit   m_inpkt;
   bit   m_seen;
   int   checks = 0;
   int   failures = 0;

   always #5 axis_aclk = ~axis_aclk;

   timestamp_extract #(.SYNC_VLAN_ID(VID), .FIFO_DEPTH(DEPTH), .NUM_SLOTS(3)) dut (
      .axis_aclk    (axis_aclk),
      .axis_areset  (axis_areset),
      .i_axis_tvalid(tvalid),
      .i_axis_tdata (tdata),
      .i_axis_tkeep (tkeep),
      .i_axis_tlast (tlast),
      .i_axis_tready(tready),
      .i_curr_tick  (curr_tick),
      .o_rec_valid  (o_rec_valid),
      .i_rec_ready  (rec_ready),
      .o_rec_data   (o_rec_data),
      .o_rec_last   (o_rec_last),
      .o_fifo_level (o_fifo_level),
      .o_sync_seen  (o_sync_seen),
      .o_rec_count  (o_rec_count),
      .o_drop_count (o_drop_count)
   );

   task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] randData();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] mkSync(input logic [511:0] d, input logic [11:0] vid);
      logic [511:0] r;
      r = d;
      r[103:96]  = 8'h81;
      r[111:104] = 8'h00;
      r[115:112] = vid[11:8];
      r[127:120] = vid[7:0];
      return r;
   endfunction

   function automatic logic [511:0] setSlot(input logic [511:0] d, input int k,
                                            input logic [31:0] nb, input logic [63:0] tx);
      logic [511:0] r;
      r = d;
      r[144+96*k +: 64] = tx;
      r[208+96*k +: 32] = nb;
      return r;
   endfunction

   function automatic bit isSync(input logic [511:0] d);
      return d[103:96] == 8'h81 && d[111:104] == 8'h00 && {d[115:112], d[127:120]} == VID;
   endfunction

   // Model one clock edge: pop, serializer push (or full drop), then framing/capture
   task automatic modelStep();
      bit   busy;
      rec_t r;
      busy   = mpend.size() != 0;
      m_seen = 0;
      if (mq.size() != 0 && rec_ready) void'(mq.pop_front());
      if (busy) begin
         r = mpend.pop_front();
         if (mq.size() < DEPTH) begin
            mq.push_back(r);
            m_recs++;
         end else m_drops++;
      end
      if (tvalid && tready) begin
         if (!m_inpkt && isSync(tdata)) begin
            if (busy) m_drops++;
            else begin
               m_seen = 1;
               for (int k = 0; k < 3; k++) begin
                  if (tdata[144+96*k +: 32] != 32'hDEADBEEF && (&tkeep[18+12*k +: 12])) begin
                     r.idx  = 2'(k);
                     r.tx   = tdata[144+96*k +: 64];
                     r.nb   = tdata[208+96*k +: 32];
                     r.rx   = curr_tick;
                     r.last = 1'b0;
                     mpend.push_back(r);
                  end
               end
               if (mpend.size() != 0) mpend[mpend.size()-1].last = 1'b1;
            end
         end
         m_inpkt = !tlast;
      end
   endtask

   task automatic checkOutput();
      chk("valid", o_rec_valid, mq.size() != 0);
      chk("level", o_fifo_level, mq.size());
      if (mq.size() != 0) chk("rec", {o_rec_data, o_rec_last}, mq[0]);
      chk("sync_seen", o_sync_seen, m_seen);
      chk("rec_count", o_rec_count, m_recs);
      chk("drop_count", o_drop_count, m_drops);
   endtask

   task automatic tick();
      modelStep();
      @(posedge axis_aclk);
      #1;
      checkOutput();
      curr_tick = curr_tick + 64'd1;
   endtask

   task automatic idle(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         tvalid = 1'b0;
         if (rnd) rec_ready = 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   task automatic applyStimulus(input logic [511:0] d, input logic [63:0] kp,
                                input logic lst, input bit rnd);
      bit acc;
      tdata = d;
      tkeep = kp;
      tlast = lst;
      do begin
         tvalid = 1'b1;
         tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rnd) rec_ready = 1'($urandom_range(0, 1));
         acc = tready;
         tick();
      end while (!acc);
      tvalid = 1'b0;
      tready = 1'b0;
   endtask

   // Reset is raised between edges so its effect on the outputs must be immediate
   task automatic applyReset();
      axis_areset = 1'b1;
      #1;
      mq.delete();
      mpend.delete();
      m_recs  = 0;
      m_drops = 0;
      m_inpkt = 0;
      m_seen  = 0;
      chk("rst_valid", o_rec_valid, 0);
      chk("rst_level", o_fifo_level, 0);
      chk("rst_data", o_rec_data, 0);
      chk("rst_last", o_rec_last, 0);
      chk("rst_seen", o_sync_seen, 0);
      chk("rst_rec_count", o_rec_count, 0);
      chk("rst_drop_count", o_drop_count, 0);
      @(posedge axis_aclk);
      #1;
      axis_areset = 1'b0;
   endtask

   function automatic logic [511:0] full3();
      logic [511:0] d;
      d = mkSync(randData(), VID);
      for (int k = 0; k < 3; k++) d = setSlot(d, k, $urandom, {$urandom, 32'(k + 1)});
      return d;
   endfunction

   task automatic randPacket();
      logic [511:0] d;
      logic [63:0]  kp;
      int           nb;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
         d  = randData();
         kp = '1;
         if (b == 0 && $urandom_range(0, 3) != 0) begin
            d = mkSync(d, ($urandom_range(0, 5) == 0) ? 12'h05B : VID);
            for (int k = 0; k < 3; k++)
               if ($urandom_range(0, 3) == 0) d[144+96*k +: 32] = 32'hDEADBEEF;
            if ($urandom_range(0, 3) == 0) kp[$urandom_range(18, 53)] = 1'b0;
         end else if (b > 0 && $urandom_range(0, 1) == 1) begin
            d = mkSync(d, VID);
         end
         applyStimulus(d, kp, b == nb - 1, 1'b1);
      end
   endtask

   initial begin
      logic [511:0] d;
      #2;
      applyReset();

      $display("[TB] two-slot sync packet");
      rec_ready = 1'b1;
      d = mkSync(randData(), VID);
      d = setSlot(d, 0, 32'h1, 64'h100);
      d = setSlot(d, 1, 32'h2, 64'h200);
      d = setSlot(d, 2, $urandom, {$urandom, 32'hDEADBEEF});
      curr_tick = 64'd500;
      applyStimulus(d, '1, 1'b1, 1'b0);
      chk("t1_seen", o_sync_seen, 1);
      tick();
      chk("t1_rec0", {o_rec_data, o_rec_last}, {2'd0, 32'h1, 64'h100, 64'd500, 1'b0});
      tick();
      chk("t1_rec1", {o_rec_data, o_rec_last}, {2'd1, 32'h2, 64'h200, 64'd500, 1'b1});
      idle(3, 1'b0);
      chk("t1_count", o_rec_count, 2);

      $display("[TB] wrong VLAN and sync-like continuation beats");
      applyStimulus(mkSync(full3(), 12'h05B), '1, 1'b1, 1'b0);
      applyStimulus(mkSync(full3(), 12'h05B), '1, 1'b0, 1'b0);
      applyStimulus(full3(), '1, 1'b0, 1'b0);
      applyStimulus(full3(), '1, 1'b0, 1'b0);
      applyStimulus(full3(), '1, 1'b1, 1'b0);
      idle(5, 1'b0);
      chk("t2_count", o_rec_count, 2);
      chk("t2_drops", o_drop_count, 0);

      $display("[TB] trailing bytes not kept");
      applyStimulus(full3(), 64'h0000_03FF_FFFF_FFFF, 1'b1, 1'b0);
      idle(5, 1'b0);
      chk("t3_count", o_rec_count, 4);

      $display("[TB] FIFO overflow with consumer stalled");
      applyReset();
      rec_ready = 1'b0;
      applyStimulus(full3(), '1, 1'b1, 1'b0);
      idle(7, 1'b0);
      applyStimulus(full3(), '1, 1'b1, 1'b0);
      idle(6, 1'b0);
      chk("t4_level", o_fifo_level, 4);
      chk("t4_drops", o_drop_count, 2);
      chk("t4_count", o_rec_count, 4);
      rec_ready = 1'b1;
      idle(6, 1'b0);

      $display("[TB] back-to-back sync packets");
      applyReset();
      applyStimulus(full3(), '1, 1'b1, 1'b0);
      applyStimulus(full3(), '1, 1'b1, 1'b0);
      idle(6, 1'b0);
      chk("t5_drops", o_drop_count, 1);
      chk("t5_count", o_rec_count, 3);

      $display("[TB] reset during serialization");
      rec_ready = 1'b0;
      applyStimulus(full3(), '1, 1'b1, 1'b0);
      idle(2, 1'b0);
      chk("t6_level_before", o_fifo_level, 2);
      applyReset();
      rec_ready = 1'b1;
      applyStimulus(full3(), '1, 1'b1, 1'b0);
      idle(5, 1'b0);
      chk("t6_count_after", o_rec_count, 3);

      $display("[TB] random traffic");
      for (int p = 0; p < 60; p++) begin
         idle($urandom_range(0, 3), 1'b1);
         randPacket();
      end
      rec_ready = 1'b1;
      idle(10, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timestamp_extract.md
Name: timestamp_extract

Overview:
- Receive-side stage directly downstream of the timestamp injector on the sync path; passive tap on one 512-bit AXI-stream (never back-pressures it).
- On the first beat of each sync packet, unpacks every occupied 96-bit timestamp slot and tags it with the local receive tick.
- Queues the resulting records in a FIFO; host-side logic pops them over a valid/ready record stream for one-way latency computation.

Parameters:
- SYNC_VLAN_ID, 12'h05A, VLAN ID identifying a sync packet.
- FIFO_DEPTH, 16, record FIFO entries; power of two, 4..256.
- NUM_SLOTS, 3, timestamp slots scanned. Fixed by frame layout: offsets 144+96*k bits, k<3.

Ports:
- axis_aclk  in  1  sole clock.
- axis_areset  in  1  asynchronous, active-high reset.
- i_axis_tvalid  in  1  monitored stream valid.
- i_axis_tdata  in  512  monitored data; byte b = bits [8b+7:8b].
- i_axis_tkeep  in  64  monitored byte enables.
- i_axis_tlast  in  1  monitored end of packet.
- i_axis_tready  in  1  monitored ready; beat accepted when tvalid&tready.
- i_curr_tick  in  64  free-running local tick.
- o_rec_valid  out  1  record available.
- i_rec_ready  in  1  consumer pops record when o_rec_valid&i_rec_ready.
- o_rec_data  out  162  {slot_idx[1:0], nb_sync[31:0], tx_tick[63:0], rx_tick[63:0]}, MSB first.
- o_rec_last  out  1  record is the last occupied slot of its packet.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_sync_seen  out  1  one-cycle pulse per sync packet captured.
- o_rec_count  out  32  records written to FIFO; saturating.
- o_drop_count  out  32  lost events; saturating.

Behaviour:
- Reset asserted: FSM→SOF, serializer idle, FIFO emptied. All outputs 0, including o_rec_data, the counters and o_fifo_level.
- Framing FSM, two states, advances only on accepted beats:
  - SOF: first beat processed; →MID if !tlast, else stay SOF.
  - MID: beat ignored; →SOF on tlast.
- After reset, the first accepted beat is treated as SOF, even mid-packet.
- Sync packet: first beat with bytes 12..13 = 8'h81,8'h00 and {byte14[3:0],byte15} = SYNC_VLAN_ID.
- Slot k occupies tdata[144+96k +: 96]:
  - tx_tick = low 64 bits; nb_sync = upper 32 bits.
  - Occupied iff tdata[144+96k +: 32] != 32'hDEADBEEF and tkeep bytes 18+12k..29+12k are all 1.
- Capture: sync first beat accepted in cycle N, serializer idle.
  - Edge ending N latches the slots, the occupancy mask and rx_tick = i_curr_tick sampled in cycle N.
  - o_sync_seen pulses in cycle N+1.
- Serializer: writes one record per cycle, in ascending slot order, in cycles N+1..N+m, m = occupied count.
  - o_rec_last is set on the m-th record.
  - m=0: no writes, but o_sync_seen still pulses.
  - Busy during N+1..N+m.
- FIFO: first-word fall-through with registered output; a record written in cycle C is visible from C+1 when the FIFO was empty.
  - Order is preserved.
  - A simultaneous push and pop at full or empty is legal; level is unchanged.
- Push while full (and no pop in the same cycle): record discarded, o_drop_count +1. The serializer still advances.
- Sync first beat accepted while serializer busy: packet ignored (no pulse), o_drop_count +1.
- Both drop events in one cycle: o_drop_count +2.
- Counters saturate at 32'hFFFFFFFF.
- o_rec_count +1 per successful FIFO write.
- o_rec_data and o_rec_last hold while o_rec_valid && !i_rec_ready.
- Reset mid-serialization: pending records are lost and are not counted.

Test Plan:
- Single-beat sync packet, VLAN 0x05A, slots 0/1 filled ({32'h1,64'h100}, {32'h2,64'h200}), slot 2 = DEADBEEF, i_curr_tick=500 in cycle N, i_rec_ready=1 -> o_sync_seen at N+1; records (0,1,0x100,500,last=0) at N+2 and (1,2,0x200,500,last=1) at N+3; o_rec_count=2.
- Same packet with VLAN 0x05B, and a 4-beat sync packet whose beats 2..4 carry sync-like headers -> no records, no pulse, counters unchanged.
- Sync packet, all three slots occupied, tkeep bytes 42..63 = 0 -> only slots 0,1 emitted; slot 1 has last=1.
- FIFO_DEPTH=4, i_rec_ready=0, two 3-slot sync packets spaced 8 cycles apart -> level 4, o_drop_count=2, o_rec_count=4; releasing ready pops packet-1 slots 0,1,2 then packet-2 slot 0 in order.
- Two back-to-back single-beat 3-slot sync packets (consecutive cycles) -> second ignored, o_drop_count=1, exactly 3 records.
- axis_areset pulsed during serialization with 2 records queued -> o_rec_valid and level drop to 0 immediately (asynchronously), counters 0; the next sync packet is captured normally.
